alu_seq: RTL

Parametrised, handshaked ALU for the NPC datapath: accepts an operand pair and opcode over a valid/ready input channel, computes the result plus zero/carry/overflow flags, and holds them on a registered valid/ready output channel until consumed. Single-cycle ops complete in one cycle. An optional iterative shift-add multiplier takes WIDTH cycles. It replaces the fixed 4-bit combinational ALU feeding the 7-segment display path and is usable wherever a multi-cycle-tolerant ALU sits between a producer and a consumer.

---
 rtl/alu_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags on a valid/ready pair.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (op 1000).
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MUL_EN
    BUSY = 2'd2,
`endif
    DONE = 2'd1
  } state_t;

  state_t           state_q;
  logic             ovalid_q;
  logic [WIDTH-1:0] res_q;
  logic             z_q;
  logic             c_q;
  logic             v_q;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [2*WIDTH-1:0] prod;

  assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  assign in_ready  = (state_q == IDLE) ||
                     (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = ovalid_q;
  assign result    = res_q;
  assign zero      = z_q;
  assign carry     = c_q;
  assign overflow  = v_q;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    dif     = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      4'b0000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: alu_res = ~a;
      4'b0011: alu_res = a & b;
      4'b0100: alu_res = a | b;
      4'b0101: alu_res = a ^ b;
      4'b0110: alu_res = WIDTH'($signed(a) < $signed(b));
      4'b0111: alu_res = WIDTH'(a == b);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ovalid_q <= 1'b0;
      res_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_MUL_EN
      if (op == 4'b1000) begin
        state_q  <= BUSY;
        ovalid_q <= 1'b0;
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        cnt_q    <= '0;
      end else
`endif
      begin
        state_q  <= DONE;
        ovalid_q <= 1'b1;
        res_q    <= alu_res;
        z_q      <= (alu_res == '0);
        c_q      <= alu_c;
        v_q      <= alu_v;
      end
    end else begin
      unique case (state_q)
`ifdef ALU_MUL_EN
        BUSY: begin
          acc_q    <= prod;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + WIDTH'(1);
          // last multiplier bit folds in on the same edge as the load
          if (cnt_q == WIDTH'(WIDTH-1)) begin
            state_q  <= DONE;
            ovalid_q <= 1'b1;
            res_q    <= prod[WIDTH-1:0];
            z_q      <= (prod[WIDTH-1:0] == '0);
            c_q      <= |prod[2*WIDTH-1:WIDTH];
            v_q      <= 1'b0;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_q  <= IDLE;
            ovalid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
